// File: rtl/hazard_scoreboard_pkg.sv
// Shared sizing, types and the latency clamp used by the hazard scoreboard.
package hazard_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = $clog2(NUM_REGS);
  localparam int NUM_SRC  = 3;
  localparam int MAX_LAT  = 8;
  localparam int LAT_W    = $clog2(MAX_LAT + 1);
  localparam int PC_REG   = 15;
  localparam int STAT_W   = 32;

  typedef logic [LAT_W-1:0] lat_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  // A zero latency is treated as a single-cycle op; anything longer than the
  // slowest unit is clamped so the countdown always fits.
  function automatic lat_t eff_lat(input lat_t lat);
    if (lat == '0) begin
      return lat_t'(1);
    end else if (lat > lat_t'(MAX_LAT)) begin
      return lat_t'(MAX_LAT);
    end else begin
      return lat;
    end
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle: issue request, source operands, pipeline control back.
interface hazard_scoreboard_if;
  import hazard_pkg::*;

  logic                      issue_valid;
  logic                      issue_we;
  reg_idx_t                  issue_dst;
  lat_t                      issue_lat;
  logic [NUM_SRC*REG_W-1:0]  src_addr;
  logic [NUM_SRC-1:0]        src_used;
  logic                      branch_taken_e;
  logic                      pipe_hold;

  logic                      stall_f;
  logic                      stall_d;
  logic                      flush_d;
  logic                      flush_e;
  logic                      issue_fire;
  logic [NUM_REGS-1:0]       busy_mask;
  logic [STAT_W-1:0]         stall_count;

  // Decode / pipeline control side.
  modport master (
    output issue_valid, issue_we, issue_dst, issue_lat, src_addr, src_used,
           branch_taken_e, pipe_hold,
    input  stall_f, stall_d, flush_d, flush_e, issue_fire, busy_mask, stall_count
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_we, issue_dst, issue_lat, src_addr, src_used,
           branch_taken_e, pipe_hold,
    output stall_f, stall_d, flush_d, flush_e, issue_fire, busy_mask, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_reg_countdown.sv
// One pending-write countdown: load on issue, otherwise count down to zero.
module reg_countdown
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hold_i,
  input  logic load_i,
  input  lat_t load_val_i,
  output lat_t cnt_o,
  output logic busy_o
);

  lat_t cnt_q;
  lat_t cnt_d;

  // Next count: frozen on hold, a new issue beats the decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - lat_t'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard producing stall/flush/issue for decode.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave bus
);

  lat_t                cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  lat_t                pc_cnt;
  logic                pc_busy;
  lat_t                lat_e;
  logic                raw;
  logic                waw;
  logic                hazard;
  logic                pc_write;
  logic                stall_f;
  logic                stall_d;
  logic                flush_d;
  logic                flush_e;
  logic                fire;
  logic [STAT_W-1:0]   stall_count_q;
  logic [STAT_W-1:0]   stall_count_d;

  assign lat_e = eff_lat(bus.issue_lat);

  // The issue cycle is itself the first latency cycle, so a register is
  // loaded with lat-1: latency 1 leaves nothing pending for the next
  // instruction, latency 2 costs exactly one bubble.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      reg_countdown u_cnt (
        .clk        (clk),
        .reset      (reset),
        .hold_i     (bus.pipe_hold),
        .load_i     (fire && bus.issue_we && (bus.issue_dst == reg_idx_t'(gi))),
        .load_val_i (lat_e - lat_t'(1)),
        .cnt_o      (cnt[gi]),
        .busy_o     (busy[gi])
      );
    end
  endgenerate

  // The PC redirect waits until the new PC has passed writeback (lat + 2).
  // MAX_LAT + 2 must fit in LAT_W bits.
  reg_countdown u_pc_cnt (
    .clk        (clk),
    .reset      (reset),
    .hold_i     (bus.pipe_hold),
    .load_i     (pc_write),
    .load_val_i (lat_e + lat_t'(2)),
    .cnt_o      (pc_cnt),
    .busy_o     (pc_busy)
  );

  // Hazard detection: any used source still pending, or a write that would
  // complete before an older pending write to the same register.
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.src_used[i] && (cnt[bus.src_addr[i*REG_W +: REG_W]] != '0)) begin
        raw = 1'b1;
      end
    end
    waw    = bus.issue_we && (cnt[bus.issue_dst] > lat_e);
    hazard = bus.issue_valid && (raw || waw || pc_busy);
  end

  // Pipeline control by priority: back-end hold, branch squash, hazard
  // bubble, issue; a pending PC write additionally keeps fetch parked and
  // feeds decode bubbles.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    fire     = 1'b0;
    pc_write = 1'b0;
    if (bus.pipe_hold) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else if (bus.branch_taken_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      if (hazard) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        fire = bus.issue_valid;
      end
      pc_write = fire && bus.issue_we && (bus.issue_dst == reg_idx_t'(PC_REG));
      if (pc_busy || pc_write) begin
        stall_f = 1'b1;
        flush_d = 1'b1;
      end
    end
  end

  // Saturating decode-stall statistic.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_d && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STAT_W'(1);
    end
  end

  // Statistic register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall_f     = stall_f;
  assign bus.stall_d     = stall_d;
  assign bus.flush_d     = flush_d;
  assign bus.flush_e     = flush_e;
  assign bus.issue_fire  = fire;
  assign bus.busy_mask   = busy;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; ctl = {stall_f,stall_d,flush_d,flush_e,issue_fire}.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  logic [4:0] ctl;

  always #5 clk = ~clk;

  hazard_scoreboard_if sb_if ();

  hazard_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb_if)
  );

  assign ctl = {sb_if.stall_f, sb_if.stall_d, sb_if.flush_d, sb_if.flush_e, sb_if.issue_fire};

  task automatic drive(input logic v, input logic we, input logic [REG_W-1:0] dst,
                       input logic [LAT_W-1:0] lat, input logic [REG_W-1:0] src,
                       input logic used, input logic br, input logic hold);
    sb_if.issue_valid    = v;
    sb_if.issue_we       = we;
    sb_if.issue_dst      = dst;
    sb_if.issue_lat      = lat;
    sb_if.src_addr       = '0;
    sb_if.src_addr[REG_W-1:0] = src;
    sb_if.src_used       = '0;
    sb_if.src_used[0]    = used;
    sb_if.branch_taken_e = br;
    sb_if.pipe_hold      = hold;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    if (ctl !== 5'b00000) begin err_cnt++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b00000); end
    cmp_cnt++;
    if (sb_if.busy_mask !== 16'h0000) begin err_cnt++; $display("FAIL reset_busy got=%h exp=%h", sb_if.busy_mask, 16'h0000); end
    cmp_cnt++;
    if (sb_if.stall_count !== 32'd0) begin err_cnt++; $display("FAIL reset_stat got=%0d exp=0", sb_if.stall_count); end
    cmp_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_alu_forward();
    do_reset();
    drive(1'b1, 1'b1, 4'd1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0); #1;
    if (ctl !== 5'b00001) begin err_cnt++; $display("FAIL alu_issue got=%b exp=%b", ctl, 5'b00001); end
    cmp_cnt++;
    step();
    drive(1'b1, 1'b0, 4'd0, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0); #1;
    if (ctl !== 5'b00001) begin err_cnt++; $display("FAIL alu_dep got=%b exp=%b", ctl, 5'b00001); end
    cmp_cnt++;
    step();
    idle(); #1;
    if (sb_if.stall_count !== 32'd0) begin err_cnt++; $display("FAIL alu_stat got=%0d exp=0", sb_if.stall_count); end
    cmp_cnt++;
    $display("test_alu_forward done");
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 1'b1, 4'd2, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0); #1;
    if (ctl !== 5'b00001) begin err_cnt++; $display("FAIL load_issue got=%b exp=%b", ctl, 5'b00001); end
    cmp_cnt++;
    step();
    // Reader of r2 on source port 2.
    drive(1'b1, 1'b0, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    sb_if.src_addr = {4'd2, 4'd0, 4'd0};
    sb_if.src_used = 3'b100;
    #1;
    if (ctl !== 5'b11010) begin err_cnt++; $display("FAIL load_use_bubble got=%b exp=%b", ctl, 5'b11010); end
    cmp_cnt++;
    if (sb_if.busy_mask !== 16'h0004) begin err_cnt++; $display("FAIL load_busy got=%h exp=%h", sb_if.busy_mask, 16'h0004); end
    cmp_cnt++;
    step();
    #1;
    if (ctl !== 5'b00001) begin err_cnt++; $display("FAIL load_use_fire got=%b exp=%b", ctl, 5'b00001); end
    cmp_cnt++;
    if (sb_if.stall_count !== 32'd1) begin err_cnt++; $display("FAIL load_stat got=%0d exp=1", sb_if.stall_count); end
    cmp_cnt++;
    $display("test_load_use done");
  endtask

  task automatic test_waw();
    do_reset();
    drive(1'b1, 1'b1, 4'd3, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0); #1;
    if (ctl !== 5'b00001) begin err_cnt++; $display("FAIL waw_first got=%b exp=%b", ctl, 5'b00001); end
    cmp_cnt++;
    step();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 4'd3, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0); #1;
      if (ctl !== 5'b11010) begin err_cnt++; $display("FAIL waw_stall%0d got=%b exp=%b", c, ctl, 5'b11010); end
      cmp_cnt++;
      if (sb_if.busy_mask !== 16'h0008) begin err_cnt++; $display("FAIL waw_busy%0d got=%h exp=%h", c, sb_if.busy_mask, 16'h0008); end
      cmp_cnt++;
      step();
    end
    #1;
    if (ctl !== 5'b00001) begin err_cnt++; $display("FAIL waw_fire got=%b exp=%b", ctl, 5'b00001); end
    cmp_cnt++;
    if (sb_if.stall_count !== 32'd4) begin err_cnt++; $display("FAIL waw_stat got=%0d exp=4", sb_if.stall_count); end
    cmp_cnt++;
    step();
    idle(); #1;
    if (sb_if.busy_mask !== 16'h0000) begin err_cnt++; $display("FAIL waw_busy_end got=%h exp=%h", sb_if.busy_mask, 16'h0000); end
    cmp_cnt++;
    $display("test_waw done");
  endtask

  task automatic test_lat_clamp();
    do_reset();
    // Latency 12 clamps to 8: seven bubbles for a dependent.
    drive(1'b1, 1'b1, 4'd7, 4'd12, 4'd0, 1'b0, 1'b0, 1'b0); #1;
    step();
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 1'b0, 4'd0, 4'd1, 4'd7, 1'b1, 1'b0, 1'b0); #1;
      if (ctl !== 5'b11010) begin err_cnt++; $display("FAIL clamp_stall%0d got=%b exp=%b", c, ctl, 5'b11010); end
      cmp_cnt++;
      step();
    end
    #1;
    if (ctl !== 5'b00001) begin err_cnt++; $display("FAIL clamp_fire got=%b exp=%b", ctl, 5'b00001); end
    cmp_cnt++;
    step();
    // Latency 0 behaves as latency 1: dependent issues next cycle.
    drive(1'b1, 1'b1, 4'd8, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); #1;
    step();
    drive(1'b1, 1'b0, 4'd0, 4'd1, 4'd8, 1'b1, 1'b0, 1'b0); #1;
    if (ctl !== 5'b00001) begin err_cnt++; $display("FAIL lat0_dep got=%b exp=%b", ctl, 5'b00001); end
    cmp_cnt++;
    $display("test_lat_clamp done");
  endtask

  task automatic test_pipe_hold();
    do_reset();
    drive(1'b1, 1'b1, 4'd4, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0); #1;
    step();
    // Held for three cycles; a taken branch in the last one is ignored.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 4'd0, 4'd1, 4'd4, 1'b1, (c == 2), 1'b1); #1;
      if (ctl !== 5'b11000) begin err_cnt++; $display("FAIL hold_ctl%0d got=%b exp=%b", c, ctl, 5'b11000); end
      cmp_cnt++;
      if (sb_if.busy_mask !== 16'h0010) begin err_cnt++; $display("FAIL hold_busy%0d got=%h exp=%h", c, sb_if.busy_mask, 16'h0010); end
      cmp_cnt++;
      step();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 4'd0, 4'd1, 4'd4, 1'b1, 1'b0, 1'b0); #1;
      if (ctl !== 5'b11010) begin err_cnt++; $display("FAIL hold_resume%0d got=%b exp=%b", c, ctl, 5'b11010); end
      cmp_cnt++;
      step();
    end
    #1;
    if (ctl !== 5'b00001) begin err_cnt++; $display("FAIL hold_fire got=%b exp=%b", ctl, 5'b00001); end
    cmp_cnt++;
    $display("test_pipe_hold done");
  endtask

  task automatic test_branch_squash();
    do_reset();
    drive(1'b1, 1'b1, 4'd5, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0); #1;
    step();
    drive(1'b1, 1'b1, 4'd6, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0); #1;
    if (ctl !== 5'b11010) begin err_cnt++; $display("FAIL br_raw got=%b exp=%b", ctl, 5'b11010); end
    cmp_cnt++;
    step();
    drive(1'b1, 1'b1, 4'd6, 4'd2, 4'd5, 1'b1, 1'b1, 1'b0); #1;
    if (ctl !== 5'b00110) begin err_cnt++; $display("FAIL br_flush got=%b exp=%b", ctl, 5'b00110); end
    cmp_cnt++;
    step();
    idle(); #1;
    if (sb_if.busy_mask !== 16'h0000) begin err_cnt++; $display("FAIL br_no_entry got=%h exp=%h", sb_if.busy_mask, 16'h0000); end
    cmp_cnt++;
    $display("test_branch_squash done");
  endtask

  task automatic test_pc_redirect();
    do_reset();
    drive(1'b1, 1'b1, 4'd15, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0); #1;
    if (ctl !== 5'b10101) begin err_cnt++; $display("FAIL pc_issue got=%b exp=%b", ctl, 5'b10101); end
    cmp_cnt++;
    step();
    idle(); #1;
    if (ctl !== 5'b10100) begin err_cnt++; $display("FAIL pc_wait1 got=%b exp=%b", ctl, 5'b10100); end
    cmp_cnt++;
    step();
    drive(1'b1, 1'b0, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0); #1;
    if (ctl !== 5'b11110) begin err_cnt++; $display("FAIL pc_wait2 got=%b exp=%b", ctl, 5'b11110); end
    cmp_cnt++;
    step();
    idle(); #1;
    if (ctl !== 5'b10100) begin err_cnt++; $display("FAIL pc_wait3 got=%b exp=%b", ctl, 5'b10100); end
    cmp_cnt++;
    step();
    #1;
    if (ctl !== 5'b00000) begin err_cnt++; $display("FAIL pc_done got=%b exp=%b", ctl, 5'b00000); end
    cmp_cnt++;
    $display("test_pc_redirect done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 1'b1, 4'd9, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0); #1;
    step();
    drive(1'b1, 1'b1, 4'd15, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0); #1;
    step();
    drive(1'b1, 1'b0, 4'd0, 4'd1, 4'd9, 1'b1, 1'b0, 1'b0); #1;
    if (ctl !== 5'b11110) begin err_cnt++; $display("FAIL rst_pre got=%b exp=%b", ctl, 5'b11110); end
    cmp_cnt++;
    step();
    // Asynchronous reset between clock edges.
    idle();
    reset = 1'b1;
    #1;
    if (ctl !== 5'b00000) begin err_cnt++; $display("FAIL rst_mid_ctl got=%b exp=%b", ctl, 5'b00000); end
    cmp_cnt++;
    if (sb_if.busy_mask !== 16'h0000) begin err_cnt++; $display("FAIL rst_mid_busy got=%h exp=%h", sb_if.busy_mask, 16'h0000); end
    cmp_cnt++;
    if (sb_if.stall_count !== 32'd0) begin err_cnt++; $display("FAIL rst_mid_stat got=%0d exp=0", sb_if.stall_count); end
    cmp_cnt++;
    #1;
    reset = 1'b0;
    step();
    drive(1'b1, 1'b0, 4'd0, 4'd1, 4'd9, 1'b1, 1'b0, 1'b0); #1;
    if (ctl !== 5'b00001) begin err_cnt++; $display("FAIL rst_after got=%b exp=%b", ctl, 5'b00001); end
    cmp_cnt++;
    $display("test_reset_mid done");
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_forward();
    test_load_use();
    test_waw();
    test_lat_clamp();
    test_pipe_hold();
    test_branch_squash();
    test_pc_redirect();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
